morph_ctrl: RTL and testbench

MORPH_CTRL -- requirements
Module: morph_ctrl

---
 rtl/morph_pkg.sv | 23 ++
 rtl/morph_ctrl_if.sv | 25 ++
 rtl/morph_pos_cnt.sv | 73 +++++++
 rtl/morph_ctrl.sv | 160 ++++++++++++++++
 tb/tb_morph_ctrl.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/morph_pkg.sv
// Shared definitions for the morphology controller slice.
// Holds the operation encodings driven on op_sel / accepted on cfg_mode,
// the controller FSM state type and the position counter widths.
package morph_pkg;

  typedef logic [1:0] op_t;

  localparam op_t OP_BYPASS = 2'b00;
  localparam op_t OP_ERODE  = 2'b01;
  localparam op_t OP_DILATE = 2'b10;
  localparam op_t OP_OPEN   = 2'b11;  // erode then dilate

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StWaitVs = 2'd1,
    StActive = 2'd2,
    StFlush  = 2'd3
  } state_e;

  localparam int unsigned ColW = 11;
  localparam int unsigned RowW = 10;

endpackage

// File: rtl/morph_ctrl_if.sv
// Configuration handshake bundle for morph_ctrl.
//   cfg_mode  : requested operation (op_t encoding)
//   cfg_valid : requester has a mode to hand over
//   cfg_ready : controller can accept (always high in this design)
// master = requester side, slave = morph_ctrl side.
interface morph_ctrl_if;
  import morph_pkg::*;

  op_t  cfg_mode;
  logic cfg_valid;
  logic cfg_ready;

  modport master (
    output cfg_mode,
    output cfg_valid,
    input  cfg_ready
  );

  modport slave (
    input  cfg_mode,
    input  cfg_valid,
    output cfg_ready
  );

endinterface

// File: rtl/morph_pos_cnt.sv
// Pixel position tracker for the morphology window.
// Keeps an internal "next pixel" position and, for every counted pixel,
// registers that pixel's column/row plus the 3x3-window-incomplete flag.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clr_i         : frame restart, returns everything to 0
//   pix_vld_i     : a pixel is counted this cycle
//   col_cnt_o     : column of the last counted pixel
//   row_cnt_o     : row of the last counted pixel
//   border_o      : window around that pixel crosses the frame edge
//   last_o        : the pixel counted this cycle is the final one of the frame
//   pos_col_o     : column the next pixel will receive (0 after a line wrap)
module morph_pos_cnt
  import morph_pkg::*;
#(
  parameter int unsigned H_ACT = 640,
  parameter int unsigned V_ACT = 480
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clr_i,
  input  logic            pix_vld_i,
  output logic [ColW-1:0] col_cnt_o,
  output logic [RowW-1:0] row_cnt_o,
  output logic            border_o,
  output logic            last_o,
  output logic [ColW-1:0] pos_col_o
);

  localparam logic [ColW-1:0] ColLast = ColW'(H_ACT - 1);
  localparam logic [RowW-1:0] RowLast = RowW'(V_ACT - 1);

  logic [ColW-1:0] pos_col_q;
  logic [RowW-1:0] pos_row_q;
  logic            border_d;

  always_comb begin
    border_d = (pos_row_q < RowW'(2)) || (pos_col_q < ColW'(2)) ||
               (pos_col_q == ColLast) || (pos_row_q == RowLast);
  end

  assign last_o    = pix_vld_i && (pos_col_q == ColLast) && (pos_row_q == RowLast);
  assign pos_col_o = pos_col_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pos_col_q <= '0;
      pos_row_q <= '0;
      col_cnt_o <= '0;
      row_cnt_o <= '0;
      border_o  <= 1'b0;
    end else if (clr_i) begin
      pos_col_q <= '0;
      pos_row_q <= '0;
      col_cnt_o <= '0;
      row_cnt_o <= '0;
      border_o  <= 1'b0;
    end else if (pix_vld_i) begin
      col_cnt_o <= pos_col_q;
      row_cnt_o <= pos_row_q;
      border_o  <= border_d;
      if (pos_col_q == ColLast) begin
        pos_col_q <= '0;
        // Row saturates so stray pixels after the frame stay on the last line.
        if (pos_row_q != RowLast) begin
          pos_row_q <= pos_row_q + RowW'(1);
        end
      end else begin
        pos_col_q <= pos_col_q + ColW'(1);
      end
    end
  end

endmodule

// File: rtl/morph_ctrl.sv
// Frame controller for a 3x3 morphology stage.
// Accepts an operation over the cfg handshake, latches it into op_sel at the
// start of each frame, tracks pixel position, gates the line buffer and
// inserts a drain gap of FLUSH_CYC cycles after the last pixel.
//   sclk, s_rst_n            : clock, asynchronous active-low reset
//   vsync_i/hsync_i/data_en_i: video timing (vsync rise = frame start,
//                              pixels with hsync high are ignored)
//   cfg_if (slave)           : cfg_mode / cfg_valid / cfg_ready
//   op_sel                   : operation applied to the current frame
//   lb_clken, lb_flush       : line-buffer enable and clear pulse
//   col_cnt, row_cnt         : position of the current pixel
//   border_o                 : 3x3 window incomplete for that pixel
//   busy                     : frame in progress (ACTIVE or FLUSH)
// Optional MORPH_CTRL_STAT_EN adds frame_cnt (completed frames, wrapping)
// and len_err (sticky short/long line flag).
module morph_ctrl
  import morph_pkg::*;
#(
  parameter int unsigned H_ACT     = 640,
  parameter int unsigned V_ACT     = 480,
  parameter int unsigned FLUSH_CYC = 4
) (
  input  logic            sclk,
  input  logic            s_rst_n,
  input  logic            vsync_i,
  input  logic            hsync_i,
  input  logic            data_en_i,
  morph_ctrl_if.slave     cfg_if,
  output op_t             op_sel,
  output logic            lb_clken,
  output logic            lb_flush,
  output logic [ColW-1:0] col_cnt,
  output logic [RowW-1:0] row_cnt,
  output logic            border_o,
  output logic            busy
`ifdef MORPH_CTRL_STAT_EN
  ,
  output logic [15:0]     frame_cnt,
  output logic            len_err
`endif
);

  localparam int unsigned    FcW    = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
  localparam logic [FcW-1:0] FcLast = FcW'(FLUSH_CYC - 1);

  state_e          state_q;
  op_t             pend_q;
  logic            vsync_q;
  logic [FcW-1:0]  flush_cnt_q;

  logic            vs_rise;
  logic            de_qual;
  logic            cfg_acc;
  op_t             mode_now;
  logic            pix_vld;
  logic            pix_last;
  logic [ColW-1:0] pos_col;

  assign cfg_if.cfg_ready = 1'b1;

  assign vs_rise  = vsync_i && !vsync_q;
  assign de_qual  = data_en_i && !hsync_i;
  assign cfg_acc  = cfg_if.cfg_valid && cfg_if.cfg_ready;
  // An accept in the same cycle as the frame start wins over the pending value.
  assign mode_now = cfg_acc ? cfg_if.cfg_mode : pend_q;
  assign pix_vld  = (state_q == StActive) && de_qual && !vs_rise;

  morph_pos_cnt #(
    .H_ACT (H_ACT),
    .V_ACT (V_ACT)
  ) u_pos_cnt (
    .clk_i     (sclk),
    .rst_ni    (s_rst_n),
    .clr_i     (vs_rise),
    .pix_vld_i (pix_vld),
    .col_cnt_o (col_cnt),
    .row_cnt_o (row_cnt),
    .border_o  (border_o),
    .last_o    (pix_last),
    .pos_col_o (pos_col)
  );

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state_q     <= StIdle;
      pend_q      <= OP_BYPASS;
      op_sel      <= OP_BYPASS;
      vsync_q     <= 1'b0;
      flush_cnt_q <= '0;
      lb_clken    <= 1'b0;
      lb_flush    <= 1'b0;
      busy        <= 1'b0;
    end else begin
      vsync_q  <= vsync_i;
      lb_clken <= de_qual && (state_q == StActive);
      lb_flush <= vs_rise;
      if (cfg_acc) begin
        pend_q <= cfg_if.cfg_mode;
      end
      unique case (state_q)
        StIdle: begin
          if (cfg_acc) begin
            state_q <= StWaitVs;
          end
        end
        StWaitVs: begin
          if (vs_rise) begin
            state_q <= StActive;
            op_sel  <= mode_now;
            busy    <= 1'b1;
          end
        end
        StActive: begin
          if (vs_rise) begin
            // Short frame: restart in place with the newest mode.
            op_sel <= mode_now;
          end else if (pix_last) begin
            state_q     <= StFlush;
            lb_flush    <= 1'b1;
            flush_cnt_q <= '0;
          end
        end
        StFlush: begin
          if (flush_cnt_q == FcLast) begin
            state_q <= StWaitVs;
            busy    <= 1'b0;
          end else begin
            flush_cnt_q <= flush_cnt_q + FcW'(1);
          end
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
      endcase
    end
  end

`ifdef MORPH_CTRL_STAT_EN
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      frame_cnt <= '0;
      len_err   <= 1'b0;
    end else begin
      if (pix_last) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
      // lb_clken is last cycle's qualified enable, so this is a falling edge;
      // a correct line leaves the next-pixel column wrapped back to 0.
      if (lb_clken && !de_qual && (state_q == StActive) && (pos_col != '0)) begin
        len_err <= 1'b1;
      end
    end
  end
`else
  logic unused_pos_col;
  assign unused_pos_col = ^pos_col;
`endif

endmodule

// File: tb/tb_morph_ctrl.sv
module tb_morph_ctrl;
  import morph_pkg::*;

  localparam int H = 8;
  localparam int V = 6;
  localparam int F = 4;

  logic        sclk;
  logic        s_rst_n;
  logic        vsync, hsync, de;
  op_t         op_sel;
  logic        lb_clken, lb_flush, border, busy;
  logic [10:0] col_cnt;
  logic [9:0]  row_cnt;
`ifdef MORPH_CTRL_STAT_EN
  logic [15:0] frame_cnt;
  logic        len_err;
`endif

  morph_ctrl_if cfg_if ();

  morph_ctrl #(
    .H_ACT     (H),
    .V_ACT     (V),
    .FLUSH_CYC (F)
  ) dut (
    .sclk      (sclk),
    .s_rst_n   (s_rst_n),
    .vsync_i   (vsync),
    .hsync_i   (hsync),
    .data_en_i (de),
    .cfg_if    (cfg_if.slave),
    .op_sel    (op_sel),
    .lb_clken  (lb_clken),
    .lb_flush  (lb_flush),
    .col_cnt   (col_cnt),
    .row_cnt   (row_cnt),
    .border_o  (border),
    .busy      (busy)
`ifdef MORPH_CTRL_STAT_EN
    ,
    .frame_cnt (frame_cnt),
    .len_err   (len_err)
`endif
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  int checks;
  int failures;
  int m_col, m_row, m_op;

  typedef struct {
    logic       vs, de, hs, cv;
    logic [1:0] cm;
    int         op, busy, flush, clken, col, row, border;
  } vec_t;

  vec_t vecs[7];

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int op, input int bsy, input int fl,
                         input int ce, input int c, input int r, input int b);
    chk({tag, ".op_sel"}, int'(op_sel), op);
    chk({tag, ".busy"}, int'(busy), bsy);
    chk({tag, ".lb_flush"}, int'(lb_flush), fl);
    chk({tag, ".lb_clken"}, int'(lb_clken), ce);
    chk({tag, ".col_cnt"}, int'(col_cnt), c);
    chk({tag, ".row_cnt"}, int'(row_cnt), r);
    chk({tag, ".border"}, int'(border), b);
  endtask

  // One qualified pixel; expectations come from the bench's own position model.
  task automatic px();
    int eb;
    de = 1'b1;
    tick();
    eb = ((m_row < 2) || (m_col < 2) || (m_col == H - 1) || (m_row == V - 1)) ? 1 : 0;
    chk($sformatf("px(%0d,%0d).col", m_col, m_row), int'(col_cnt), m_col);
    chk($sformatf("px(%0d,%0d).row", m_col, m_row), int'(row_cnt), m_row);
    chk($sformatf("px(%0d,%0d).border", m_col, m_row), int'(border), eb);
    chk($sformatf("px(%0d,%0d).op_sel", m_col, m_row), int'(op_sel), m_op);
    chk($sformatf("px(%0d,%0d).clken", m_col, m_row), int'(lb_clken), 1);
    if (m_col == H - 1) begin
      m_col = 0;
      if (m_row != V - 1) m_row++;
    end else begin
      m_col++;
    end
  endtask

  // Called right after the last pixel of a frame has been counted.
  task automatic flush_tail(input string tag);
    chk({tag, ".flush_entry_pulse"}, int'(lb_flush), 1);
    chk({tag, ".flush_entry_busy"}, int'(busy), 1);
    de = 1'b0;
    for (int i = 1; i <= F; i++) begin
      tick();
      chk($sformatf("%s.flush_busy%0d", tag, i), int'(busy), (i < F) ? 1 : 0);
      if (i == 1) chk({tag, ".flush_single_pulse"}, int'(lb_flush), 0);
    end
  endtask

  task automatic vs_edge(input logic cv, input logic [1:0] cm);
    vsync = 1'b1;
    cfg_if.cfg_valid = cv;
    cfg_if.cfg_mode = cm;
    de = 1'b0;
    tick();
    vsync = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    m_col = 0;
    m_row = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0;
    failures = 0;
    m_col = 0;
    m_row = 0;
    m_op = 0;
    vsync = 1'b0;
    hsync = 1'b0;
    de = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_mode = 2'b00;
    s_rst_n = 1'b0;

    //            vs  de  hs  cv  cm     op bsy fl ce col row brd
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 0, 0, 0, 0, 0, 0, 0}; // accept erode
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1, 1, 1, 0, 0, 0, 0}; // vsync rise
    vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1, 1, 0, 1, 0, 0, 1}; // pixel (0,0)
    vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1, 1, 0, 1, 1, 0, 1}; // pixel (1,0)
    vecs[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1, 1, 0, 0, 1, 0, 1}; // hsync masks
    vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1, 1, 0, 1, 2, 0, 1}; // pixel (2,0)
    vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1, 1, 0, 0, 2, 0, 1}; // idle holds

    repeat (2) tick();
    chk_all("reset", 0, 0, 0, 0, 0, 0, 0);
    chk("reset.cfg_ready", int'(cfg_if.cfg_ready), 1);
    s_rst_n = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) begin
      vsync = vecs[i].vs;
      de = vecs[i].de;
      hsync = vecs[i].hs;
      cfg_if.cfg_valid = vecs[i].cv;
      cfg_if.cfg_mode = vecs[i].cm;
      tick();
      chk_all($sformatf("vec%0d", i), vecs[i].op, vecs[i].busy, vecs[i].flush,
              vecs[i].clken, vecs[i].col, vecs[i].row, vecs[i].border);
    end
    hsync = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    vsync = 1'b0;

    // Rest of frame 1; dilate is requested mid-frame and must not apply yet.
    m_col = 3;
    m_row = 0;
    m_op = 1;
    for (int i = 0; i < H * V - 3; i++) begin
      if (m_row == 3 && m_col == 0) begin
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_mode = 2'b10;
      end
      px();
      cfg_if.cfg_valid = 1'b0;
    end
    flush_tail("frame1");
    chk("frame1.waitvs_op_hold", int'(op_sel), 1);

    // Frame 2 picks up dilate.
    vs_edge(1'b0, 2'b00);
    m_op = 2;
    chk_all("frame2.start", 2, 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3 * H; i++) px();

    // Short frame: vsync after 3 lines with a coincident open request.
    vs_edge(1'b1, 2'b11);
    m_op = 3;
    chk_all("short.restart", 3, 1, 1, 0, 0, 0, 0);
    tick();
    chk("short.pulse_once", int'(lb_flush), 0);
    chk("short.still_active", int'(busy), 1);
    for (int i = 0; i < 2 * H + 5; i++) px();
    chk("midrst.pos_col", int'(col_cnt), 4);
    chk("midrst.pos_row", int'(row_cnt), 2);

    // Asynchronous reset mid-frame.
    s_rst_n = 1'b0;
    #1;
    chk_all("midrst", 0, 0, 0, 0, 0, 0, 0);
    tick();
    s_rst_n = 1'b1;
    tick();
    vsync = 1'b1;
    tick();
    chk("postrst.vs_no_start", int'(busy), 0);
    chk("postrst.vs_op", int'(op_sel), 0);
    vsync = 1'b0;
    tick();
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_mode = 2'b01;
    tick();
    cfg_if.cfg_valid = 1'b0;
    chk("postrst.accept_waitvs", int'(busy), 0);
    de = 1'b1;
    tick();
    chk("postrst.no_pixel_clken", int'(lb_clken), 0);
    chk("postrst.no_pixel_busy", int'(busy), 0);
    vs_edge(1'b0, 2'b00);
    m_op = 1;
    chk("postrst.resume_busy", int'(busy), 1);
    chk("postrst.resume_op", int'(op_sel), 1);
    px();
    px();

`ifdef MORPH_CTRL_STAT_EN
    chk("stat.len_err_clear", int'(len_err), 0);
    chk("stat.frame_cnt_clear", int'(frame_cnt), 0);
    for (int i = 0; i < 5; i++) px();
    de = 1'b0;
    tick();
    chk("stat.len_err_short_line", int'(len_err), 1);
    for (int f = 0; f < 2; f++) begin
      vs_edge(1'b0, 2'b00);
      for (int i = 0; i < H * V; i++) px();
      flush_tail($sformatf("stat.frame%0d", f));
      chk($sformatf("stat.frame_cnt%0d", f), int'(frame_cnt), f + 1);
    end
    chk("stat.len_err_sticky", int'(len_err), 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
